mprj_io_arbiter: RTL and testbench



---
 rtl/mprj_io_arb_pkg.sv | 33 +++
 rtl/mprj_io_arbiter_if.sv | 25 ++
 rtl/mprj_io_arbiter_rr_pick.sv | 30 +++
 rtl/mprj_io_arbiter.sv | 124 ++++++++++++
 tb/tb_mprj_io_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mprj_io_arb_pkg.sv
// mprj_io_arb_pkg: shared state type, width helpers and lane indexing
// for the mprj_io pin arbiter. No ports.
package mprj_io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        HOLD,
        RELEASE
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_HOLD  = 16;
    localparam int DEF_BURST = 4;

    localparam int IDX_W   = idx_w(DEF_NREQ);
    localparam int HOLD_W  = cnt_w(DEF_HOLD);
    localparam int BURST_W = cnt_w(DEF_BURST);

endpackage

// File: rtl/mprj_io_arbiter_if.sv
// mprj_io_arbiter_if: requester-side bus of the pin arbiter.
// req/valid/data/oeb flow to the arbiter; gnt/ack flow back.
interface mprj_io_arbiter_if
    import mprj_io_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    logic [NREQ-1:0]       req_i;
    logic [NREQ-1:0]       valid_i;
    logic [NREQ*WIDTH-1:0] data_i;
    logic [NREQ*WIDTH-1:0] oeb_i;
    logic [NREQ-1:0]       gnt_o;
    logic [NREQ-1:0]       ack_o;

    modport master (
        output req_i, valid_i, data_i, oeb_i,
        input  gnt_o, ack_o
    );

    modport slave (
        input  req_i, valid_i, data_i, oeb_i,
        output gnt_o, ack_o
    );
endinterface

// File: rtl/mprj_io_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Ports: req (requests),
// ptr (search start), idx (winner index), any (some request set).
module rr_pick
    import mprj_io_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            any
);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                sum;

    // Rotate so ptr sits at bit 0; the lowest set bit wins.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        any = |req;
        sum = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) sum = int'(ptr) + k;
        end
        if (sum >= NREQ) sum = sum - NREQ;
        idx = IW'(sum);
    end
endmodule

// File: rtl/mprj_io_arbiter.sv
// mprj_io_arbiter: round-robin owner of io_out/io_oeb with per-value hold
// and burst limit. Ports: wb_clk_i, wb_rst_i, bus (requesters), io_out,
// io_oeb (pins), owner_o (current/last owner), busy_o (not IDLE).
module mprj_io_arbiter
    import mprj_io_arb_pkg::*;
#(
    parameter int               NREQ      = DEF_NREQ,
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               HOLD_CYC  = DEF_HOLD,
    parameter int               MAX_BURST = DEF_BURST,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    mprj_io_arbiter_if.slave        bus,
    output logic [WIDTH-1:0]        io_out,
    output logic [WIDTH-1:0]        io_oeb,
    output logic [$clog2(NREQ)-1:0] owner_o,
    output logic                    busy_o
);
    localparam int IW = $clog2(NREQ);
    localparam int HW = cnt_w(HOLD_CYC);
    localparam int BW = cnt_w(MAX_BURST);

    arb_state_t      state, state_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [BW-1:0]   burst_cnt, burst_n;
    logic [IW-1:0]   rr_ptr, ptr_n, owner_n, pick_idx;
    logic            pick_any;
    logic [NREQ-1:0] gnt, gnt_n, ack, ack_n;
    logic [WIDTH-1:0] out_n, oeb_n, own_data, own_oeb;
    logic            own_req, own_valid;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (bus.req_i),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign own_req   = bus.req_i[owner_o];
    assign own_valid = bus.valid_i[owner_o];
    assign own_data  = WIDTH'(bus.data_i >> lane_lo(int'(owner_o), WIDTH));
    assign own_oeb   = WIDTH'(bus.oeb_i >> lane_lo(int'(owner_o), WIDTH));

    assign bus.gnt_o = gnt;
    assign bus.ack_o = ack;
    assign busy_o    = (state != IDLE);

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        burst_n = burst_cnt;
        ptr_n   = rr_ptr;
        owner_n = owner_o;
        gnt_n   = gnt;
        ack_n   = '0;
        out_n   = io_out;
        oeb_n   = io_oeb;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    owner_n = pick_idx;
                    gnt_n   = NREQ'(1) << pick_idx;
                    burst_n = '0;
                    state_n = GRANTED;
                end
            end
            GRANTED: begin
                if (!own_req) begin
                    state_n = RELEASE;
                end else if (own_valid) begin
                    out_n   = own_data;
                    oeb_n   = own_oeb;
                    hold_n  = HW'(HOLD_CYC - 1);
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    // gnt is the owner's one-hot, so ack stays inside it.
                    ack_n   = gnt;
                    burst_n = burst_cnt + 1'b1;
                    if ((int'(burst_cnt) + 1 == MAX_BURST) || !own_req)
                        state_n = RELEASE;
                    else
                        state_n = GRANTED;
                end else begin
                    hold_n = hold_cnt - 1'b1;
                end
            end
            RELEASE: begin
                gnt_n   = '0;
                ptr_n   = (int'(owner_o) == NREQ - 1) ? '0 : owner_o + 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
            owner_o   <= '0;
            gnt       <= '0;
            ack       <= '0;
            io_out    <= RESET_VAL;
            io_oeb    <= '1;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            burst_cnt <= burst_n;
            rr_ptr    <= ptr_n;
            owner_o   <= owner_n;
            gnt       <= gnt_n;
            ack       <= ack_n;
            io_out    <= out_n;
            io_oeb    <= oeb_n;
        end
    end
endmodule

// File: tb/tb_mprj_io_arbiter.sv
// tb_mprj_io_arbiter: directed vectors against three arbiter configs
// (hold 16/burst 16, hold 1/burst 4, hold 2/burst 1).
module tb_mprj_io_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_bc;

    mprj_io_arbiter_if #(.NREQ(4), .WIDTH(8)) if_a ();
    mprj_io_arbiter_if #(.NREQ(4), .WIDTH(8)) if_b ();
    mprj_io_arbiter_if #(.NREQ(4), .WIDTH(8)) if_c ();

    logic [7:0] io_out_a, io_oeb_a, io_out_b, io_oeb_b, io_out_c, io_oeb_c;
    logic [1:0] owner_a, owner_b, owner_c;
    logic       busy_a, busy_b, busy_c;

    mprj_io_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYC(16), .MAX_BURST(16),
                      .RESET_VAL(8'h00)) u_a (
        .wb_clk_i(clk), .wb_rst_i(rst_a), .bus(if_a),
        .io_out(io_out_a), .io_oeb(io_oeb_a),
        .owner_o(owner_a), .busy_o(busy_a));

    mprj_io_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYC(1), .MAX_BURST(4),
                      .RESET_VAL(8'h00)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst_bc), .bus(if_b),
        .io_out(io_out_b), .io_oeb(io_oeb_b),
        .owner_o(owner_b), .busy_o(busy_b));

    mprj_io_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYC(2), .MAX_BURST(1),
                      .RESET_VAL(8'h00)) u_c (
        .wb_clk_i(clk), .wb_rst_i(rst_bc), .bus(if_c),
        .io_out(io_out_c), .io_oeb(io_oeb_c),
        .owner_o(owner_c), .busy_o(busy_c));

    int checks = 0;
    int errors = 0;
    int acks_a = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("a_gnt_ack", {30'd0, $onehot0(if_a.gnt_o),
            (if_a.ack_o & ~if_a.gnt_o) == 4'd0}, 32'd3);
        chk("b_gnt_ack", {30'd0, $onehot0(if_b.gnt_o),
            (if_b.ack_o & ~if_b.gnt_o) == 4'd0}, 32'd3);
        chk("c_gnt_ack", {30'd0, $onehot0(if_c.gnt_o),
            (if_c.ack_o & ~if_c.gnt_o) == 4'd0}, 32'd3);
        if (if_a.ack_o != 4'd0) acks_a++;
    end

    typedef struct {
        logic [7:0] d;
        int         hold;
    } t1_t;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [7:0]  out;
        logic [1:0]  owner;
        logic        busy;
    } vec_t;

    t1_t  t1[12];
    vec_t tv[34];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, stable, gap, snap;
        logic [7:0] d8;
        logic [31:0] hexv;

        t1[0]  = '{8'h01, 16}; t1[1]  = '{8'h02, 16};
        t1[2]  = '{8'h03, 16}; t1[3]  = '{8'h04, 16};
        t1[4]  = '{8'h05, 16}; t1[5]  = '{8'h06, 16};
        t1[6]  = '{8'h07, 16}; t1[7]  = '{8'h08, 16};
        t1[8]  = '{8'h09, 16}; t1[9]  = '{8'h0A, 16};
        t1[10] = '{8'hFF, 16}; t1[11] = '{8'h00, 16};

        tv[0]  = '{4'h1, 4'h1, 32'h11, 4'h1, 4'h0, 8'h00, 2'd0, 1'b1};
        tv[1]  = '{4'h1, 4'h1, 32'h11, 4'h1, 4'h0, 8'h11, 2'd0, 1'b1};
        tv[2]  = '{4'h1, 4'h1, 32'h11, 4'h1, 4'h1, 8'h11, 2'd0, 1'b1};
        tv[3]  = '{4'h1, 4'h1, 32'h22, 4'h1, 4'h0, 8'h22, 2'd0, 1'b1};
        tv[4]  = '{4'h1, 4'h1, 32'h22, 4'h1, 4'h1, 8'h22, 2'd0, 1'b1};
        tv[5]  = '{4'h1, 4'h1, 32'h33, 4'h1, 4'h0, 8'h33, 2'd0, 1'b1};
        tv[6]  = '{4'h1, 4'h1, 32'h33, 4'h1, 4'h1, 8'h33, 2'd0, 1'b1};
        tv[7]  = '{4'h1, 4'h1, 32'h44, 4'h1, 4'h0, 8'h44, 2'd0, 1'b1};
        tv[8]  = '{4'h1, 4'h1, 32'h44, 4'h1, 4'h1, 8'h44, 2'd0, 1'b1};
        tv[9]  = '{4'h1, 4'h1, 32'h55, 4'h0, 4'h0, 8'h44, 2'd0, 1'b0};
        tv[10] = '{4'h1, 4'h1, 32'h55, 4'h1, 4'h0, 8'h44, 2'd0, 1'b1};
        tv[11] = '{4'h1, 4'h1, 32'h55, 4'h1, 4'h0, 8'h55, 2'd0, 1'b1};
        tv[12] = '{4'h0, 4'h0, 32'h55, 4'h1, 4'h1, 8'h55, 2'd0, 1'b1};
        tv[13] = '{4'h0, 4'h0, 32'h55, 4'h0, 4'h0, 8'h55, 2'd0, 1'b0};
        tv[14] = '{4'h6, 4'h6, 32'h00B1A100, 4'h2, 4'h0, 8'h55, 2'd1, 1'b1};
        tv[15] = '{4'h6, 4'h6, 32'h00B1A100, 4'h2, 4'h0, 8'hA1, 2'd1, 1'b1};
        tv[16] = '{4'h6, 4'h6, 32'h00B1A100, 4'h2, 4'h2, 8'hA1, 2'd1, 1'b1};
        tv[17] = '{4'h6, 4'h6, 32'h00B1A200, 4'h2, 4'h0, 8'hA2, 2'd1, 1'b1};
        tv[18] = '{4'h6, 4'h6, 32'h00B1A200, 4'h2, 4'h2, 8'hA2, 2'd1, 1'b1};
        tv[19] = '{4'h6, 4'h6, 32'h00B1A300, 4'h2, 4'h0, 8'hA3, 2'd1, 1'b1};
        tv[20] = '{4'h6, 4'h6, 32'h00B1A300, 4'h2, 4'h2, 8'hA3, 2'd1, 1'b1};
        tv[21] = '{4'h6, 4'h6, 32'h00B1A400, 4'h2, 4'h0, 8'hA4, 2'd1, 1'b1};
        tv[22] = '{4'h6, 4'h6, 32'h00B1A400, 4'h2, 4'h2, 8'hA4, 2'd1, 1'b1};
        tv[23] = '{4'h6, 4'h6, 32'h00B1A500, 4'h0, 4'h0, 8'hA4, 2'd1, 1'b0};
        tv[24] = '{4'h6, 4'h6, 32'h00B1A500, 4'h4, 4'h0, 8'hA4, 2'd2, 1'b1};
        tv[25] = '{4'h6, 4'h6, 32'h00B1A500, 4'h4, 4'h0, 8'hB1, 2'd2, 1'b1};
        tv[26] = '{4'h6, 4'h6, 32'h00B1A500, 4'h4, 4'h4, 8'hB1, 2'd2, 1'b1};
        tv[27] = '{4'h2, 4'h2, 32'h00B1A500, 4'h4, 4'h0, 8'hB1, 2'd2, 1'b1};
        tv[28] = '{4'h2, 4'h2, 32'h00B1A500, 4'h0, 4'h0, 8'hB1, 2'd2, 1'b0};
        tv[29] = '{4'h2, 4'h2, 32'h00B1A500, 4'h2, 4'h0, 8'hB1, 2'd1, 1'b1};
        tv[30] = '{4'h2, 4'h2, 32'h00B1A500, 4'h2, 4'h0, 8'hA5, 2'd1, 1'b1};
        tv[31] = '{4'h2, 4'h2, 32'h00B1A500, 4'h2, 4'h2, 8'hA5, 2'd1, 1'b1};
        tv[32] = '{4'h0, 4'h0, 32'h00B1A500, 4'h2, 4'h0, 8'hA5, 2'd1, 1'b1};
        tv[33] = '{4'h0, 4'h0, 32'h00B1A500, 4'h0, 4'h0, 8'hA5, 2'd1, 1'b0};

        rst_a = 1'b1; rst_bc = 1'b1;
        if_a.req_i = '0; if_a.valid_i = '0; if_a.data_i = '0; if_a.oeb_i = '0;
        if_b.req_i = '0; if_b.valid_i = '0; if_b.data_i = '0; if_b.oeb_i = '0;
        if_c.req_i = '0; if_c.valid_i = '0; if_c.data_i = '0; if_c.oeb_i = '0;
        repeat (3) @(negedge clk);

        chk("rst_a_gnt", if_a.gnt_o, 0);   chk("rst_a_ack", if_a.ack_o, 0);
        chk("rst_a_out", io_out_a, 8'h00); chk("rst_a_oeb", io_oeb_a, 8'hFF);
        chk("rst_a_own", owner_a, 0);      chk("rst_a_busy", busy_a, 0);
        chk("rst_b_gnt", if_b.gnt_o, 0);   chk("rst_b_out", io_out_b, 8'h00);
        chk("rst_b_oeb", io_oeb_b, 8'hFF); chk("rst_b_busy", busy_b, 0);
        chk("rst_c_gnt", if_c.gnt_o, 0);   chk("rst_c_oeb", io_oeb_c, 8'hFF);
        rst_a = 1'b0; rst_bc = 1'b0;

        // Single requester stream on config A
        if_a.req_i = 4'b0001; if_a.valid_i = 4'b0001;
        if_a.oeb_i = {24'hFFFFFF, 8'h00};
        for (int i = 0; i < 12; i++) begin
            d8 = t1[i].d;
            if_a.data_i = {8'hEE, 8'hEE, 8'hEE, d8};
            w = 0;
            do begin @(negedge clk); w++; end
            while (io_out_a !== d8 && w < 4);
            chk($sformatf("t1_out%0d", i), io_out_a, d8);
            chk($sformatf("t1_oeb%0d", i), io_oeb_a, 8'h00);
            n = 0; stable = 1;
            do begin
                @(negedge clk); n++;
                if (io_out_a !== d8 || io_oeb_a !== 8'h00) stable = 0;
            end while (if_a.ack_o[0] !== 1'b1 && n < 40);
            chk($sformatf("t1_hold%0d", i), n, t1[i].hold);
            chk($sformatf("t1_stable%0d", i), stable, 1);
        end
        if_a.req_i = '0; if_a.valid_i = '0;
        repeat (2) @(negedge clk);
        chk("t1_acks", acks_a, 12);
        chk("t1_idle", busy_a, 0);
        chk("t1_keep_oeb", io_oeb_a, 8'h00);

        // Early drop by requester 3, then rr_ptr must sit at 0
        if_a.req_i = 4'b1000;
        @(negedge clk);
        chk("t4_gnt", if_a.gnt_o, 4'b1000);
        chk("t4_own", owner_a, 3);
        if_a.req_i = 4'b0000; if_a.valid_i = 4'b1000;
        if_a.data_i = {8'h77, 8'hEE, 8'hEE, 8'h00};
        if_a.oeb_i = {8'h00, 24'hFFFFFF};
        @(negedge clk);
        chk("t4_rel_gnt", if_a.gnt_o, 4'b1000);
        @(negedge clk);
        chk("t4_idle_gnt", if_a.gnt_o, 4'b0000);
        chk("t4_busy", busy_a, 0);
        chk("t4_out", io_out_a, 8'h00);
        chk("t4_oeb", io_oeb_a, 8'h00);
        if_a.req_i = 4'b1001; if_a.valid_i = 4'b0000;
        @(negedge clk);
        chk("t4_ptr_gnt", if_a.gnt_o, 4'b0001);
        chk("t4_ptr_own", owner_a, 0);

        // Reset while hold_cnt is 7
        if_a.valid_i = 4'b0001;
        if_a.data_i = {8'h77, 8'hEE, 8'hEE, 8'h5A};
        if_a.oeb_i = {24'hFFFFFF, 8'h0F};
        @(negedge clk);
        chk("t5_out", io_out_a, 8'h5A);
        chk("t5_oeb", io_oeb_a, 8'h0F);
        repeat (8) @(negedge clk);
        snap = acks_a;
        rst_a = 1'b1;
        @(negedge clk);
        chk("t5_rst_out", io_out_a, 8'h00);
        chk("t5_rst_oeb", io_oeb_a, 8'hFF);
        chk("t5_rst_gnt", if_a.gnt_o, 0);
        chk("t5_rst_ack", if_a.ack_o, 0);
        chk("t5_rst_busy", busy_a, 0);
        if_a.req_i = '0; if_a.valid_i = '0;
        rst_a = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_no_ack", acks_a, snap);
        chk("t5_gnt_after", if_a.gnt_o, 0);

        // HOLD_CYC=1 streaming and burst limit, config B
        if_b.oeb_i = '0;
        for (int i = 0; i < 34; i++) begin
            if_b.req_i = tv[i].req;
            if_b.valid_i = tv[i].valid;
            if_b.data_i = tv[i].data;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), if_b.gnt_o, tv[i].gnt);
            chk($sformatf("v%0d_ack", i), if_b.ack_o, tv[i].ack);
            chk($sformatf("v%0d_out", i), io_out_b, tv[i].out);
            chk($sformatf("v%0d_own", i), owner_b, tv[i].owner);
            chk($sformatf("v%0d_busy", i), busy_b, tv[i].busy);
        end

        // Four-way contention, MAX_BURST=1, config C
        hexv = 32'h04030201;
        if_c.data_i = hexv; if_c.oeb_i = '0;
        if_c.req_i = 4'hF; if_c.valid_i = 4'hF;
        for (int k = 0; k < 4; k++) begin
            gap = 0;
            while (if_c.gnt_o == 4'd0 && gap < 10) begin
                @(negedge clk); gap++;
            end
            chk($sformatf("t2_gnt%0d", k), if_c.gnt_o, 32'd1 << k);
            chk($sformatf("t2_own%0d", k), owner_c, k);
            chk($sformatf("t2_gap%0d", k), gap, 1);
            n = 0;
            while (if_c.ack_o == 4'd0 && n < 20) begin
                @(negedge clk); n++;
            end
            chk($sformatf("t2_ack%0d", k), if_c.ack_o, 32'd1 << k);
            chk($sformatf("t2_ackdly%0d", k), n, 3);
            chk($sformatf("t2_out%0d", k), io_out_c, k + 1);
            if_c.req_i[k] = 1'b0; if_c.valid_i[k] = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        chk("t2_end_busy", busy_c, 0);
        chk("t2_end_out", io_out_c, 8'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
